// File: rtl/axi4_slave_mem.sv
// AXI4 slave word memory with independent write and read engines.
// IDs are echoed unchanged so an upstream crossbar can route B and R.
module axi4_slave_mem #(
    parameter int ID_W       = 6,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
    parameter int DEPTH      = 1024
) (
    input  logic                    i_ACLK,
    input  logic                    i_ARESET,
    input  logic [ID_W-1:0]         i_AWID,
    input  logic [ADDR_WIDTH-1:0]   i_AWADDR,
    input  logic [7:0]              i_AWLEN,
    input  logic [2:0]              i_AWSIZE,
    input  logic [1:0]              i_AWBURST,
    input  logic [1:0]              i_AWLOCK,
    input  logic [3:0]              i_AWCACHE,
    input  logic [2:0]              i_AWPROT,
    input  logic                    i_AWVALID,
    output logic                    o_AWREADY,
    input  logic [DATA_WIDTH-1:0]   i_WDATA,
    input  logic [DATA_WIDTH/8-1:0] i_WSTRB,
    input  logic                    i_WLAST,
    input  logic                    i_WVALID,
    output logic                    o_WREADY,
    output logic [ID_W-1:0]         o_BID,
    output logic [1:0]              o_BRESP,
    output logic                    o_BVALID,
    input  logic                    i_BREADY,
    input  logic [ID_W-1:0]         i_ARID,
    input  logic [ADDR_WIDTH-1:0]   i_ARADDR,
    input  logic [7:0]              i_ARLEN,
    input  logic [2:0]              i_ARSIZE,
    input  logic [1:0]              i_ARBURST,
    input  logic [1:0]              i_ARLOCK,
    input  logic [3:0]              i_ARCACHE,
    input  logic [2:0]              i_ARPROT,
    input  logic                    i_ARVALID,
    output logic                    o_ARREADY,
    output logic [ID_W-1:0]         o_RID,
    output logic [DATA_WIDTH-1:0]   o_RDATA,
    output logic [DATA_WIDTH/8-1:0] o_RSTRB,
    output logic                    o_RLAST,
    output logic                    o_RVALID,
    input  logic                    i_RREADY
);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int LSB    = $clog2(STRB_W);
    localparam int IDX_W  = $clog2(DEPTH);
    localparam int AW1    = ADDR_WIDTH + 1;
    localparam int SPAN   = DEPTH * STRB_W;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
    typedef enum logic {R_IDLE, R_DATA} rstate_t;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    wstate_t               r_wstate, w_wnext;
    logic [ID_W-1:0]       r_awid;
    logic [ADDR_WIDTH-1:0] r_awaddr;
    logic [7:0]            r_awlen, r_wbeat;
    logic [2:0]            r_awsize;
    logic [1:0]            r_awburst;
    logic                  r_werr;

    rstate_t               r_rstate, w_rnext;
    logic [ID_W-1:0]       r_arid;
    logic [ADDR_WIDTH-1:0] r_araddr;
    logic [7:0]            r_arlen, r_rbeat;
    logic [2:0]            r_arsize;
    logic [1:0]            r_arburst;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [STRB_W-1:0]     r_rstrb;

    logic                  w_wok, w_we, w_wlast, w_rlast;
    logic                  w_rload, w_rok, w_ridle;
    logic [IDX_W-1:0]      w_widx;
    logic [ADDR_WIDTH-1:0] w_rsel_addr;
    logic [1:0]            w_rsel_burst;
    logic                  w_unused;

    function automatic logic f_in_range(input logic [ADDR_WIDTH-1:0] a);
        logic [ADDR_WIDTH:0] off;
        off = {1'b0, a} - {1'b0, BASE_ADDR};
        return !off[ADDR_WIDTH] && (off < AW1'(SPAN));
    endfunction

    function automatic logic [IDX_W-1:0] f_idx(input logic [ADDR_WIDTH-1:0] a);
        logic [ADDR_WIDTH-1:0] off;
        off = a - BASE_ADDR;
        return IDX_W'(off >> LSB);
    endfunction

    // WRAP keeps the upper bits of the aligned container and wraps the low bits.
    function automatic logic [ADDR_WIDTH-1:0] f_next(
        input logic [ADDR_WIDTH-1:0] a,
        input logic [2:0]            size,
        input logic [7:0]            len,
        input logic [1:0]            burst
    );
        logic [2:0]            sz;
        logic [ADDR_WIDTH-1:0] inc, mask, nxt;
        sz   = (size > 3'(LSB)) ? 3'(LSB) : size;
        inc  = ADDR_WIDTH'(1) << sz;
        mask = (inc * (ADDR_WIDTH'(len) + ADDR_WIDTH'(1))) - ADDR_WIDTH'(1);
        nxt  = a + inc;
        case (burst)
            2'b00:   return a;
            2'b10:   return (a & ~mask) | (nxt & mask);
            default: return nxt;
        endcase
    endfunction

    assign w_unused = ^{i_AWLOCK, i_AWCACHE, i_AWPROT,
                        i_ARLOCK, i_ARCACHE, i_ARPROT};

    assign w_wok   = f_in_range(r_awaddr) && (r_awburst != 2'b11);
    assign w_wlast = i_WLAST || (r_wbeat == r_awlen);
    assign w_widx  = f_idx(r_awaddr);
    assign w_we    = (r_wstate == W_DATA) && i_WVALID && w_wok && !i_ARESET;
    assign o_BID   = r_awid;
    assign o_BRESP = r_werr ? 2'b10 : 2'b00;

    // Write FSM state register.
    always_ff @(posedge i_ACLK) begin
        if (i_ARESET) r_wstate <= W_IDLE;
        else          r_wstate <= w_wnext;
    end

    // Write FSM next state and handshake outputs.
    always_comb begin
        w_wnext   = r_wstate;
        o_AWREADY = 1'b0;
        o_WREADY  = 1'b0;
        o_BVALID  = 1'b0;
        case (r_wstate)
            W_IDLE: begin
                o_AWREADY = 1'b1;
                if (i_AWVALID) w_wnext = W_DATA;
            end
            W_DATA: begin
                o_WREADY = 1'b1;
                if (i_WVALID && w_wlast) w_wnext = W_RESP;
            end
            W_RESP: begin
                o_BVALID = 1'b1;
                if (i_BREADY) w_wnext = W_IDLE;
            end
            default: w_wnext = W_IDLE;
        endcase
    end

    // Write burst context: capture on AW, advance and accumulate errors per W beat.
    always_ff @(posedge i_ACLK) begin
        if (i_ARESET) begin
            r_awid    <= '0;
            r_awaddr  <= '0;
            r_awlen   <= '0;
            r_awsize  <= '0;
            r_awburst <= '0;
            r_wbeat   <= '0;
            r_werr    <= 1'b0;
        end else if (r_wstate == W_IDLE && i_AWVALID) begin
            r_awid    <= i_AWID;
            r_awaddr  <= i_AWADDR;
            r_awlen   <= i_AWLEN;
            r_awsize  <= i_AWSIZE;
            r_awburst <= i_AWBURST;
            r_wbeat   <= '0;
            r_werr    <= 1'b0;
        end else if (r_wstate == W_DATA && i_WVALID) begin
            r_awaddr <= f_next(r_awaddr, r_awsize, r_awlen, r_awburst);
            r_wbeat  <= r_wbeat + 8'd1;
            r_werr   <= r_werr || !w_wok ||
                        ((r_wbeat == r_awlen) && !i_WLAST);
        end
    end

    // Byte-lane writes into the storage array; contents survive reset.
    always_ff @(posedge i_ACLK) begin
        if (w_we) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (i_WSTRB[b]) r_mem[w_widx][b*8 +: 8] <= i_WDATA[b*8 +: 8];
            end
        end
    end

    assign w_ridle      = (r_rstate == R_IDLE);
    assign w_rlast      = (r_rbeat == r_arlen);
    assign w_rload      = w_ridle ? i_ARVALID : (i_RREADY && !w_rlast);
    assign w_rsel_addr  = w_ridle ? i_ARADDR
                        : f_next(r_araddr, r_arsize, r_arlen, r_arburst);
    assign w_rsel_burst = w_ridle ? i_ARBURST : r_arburst;
    assign w_rok        = f_in_range(w_rsel_addr) && (w_rsel_burst != 2'b11);
    assign o_RID        = r_arid;
    assign o_RDATA      = r_rdata;
    assign o_RSTRB      = r_rstrb;

    // Read FSM state register.
    always_ff @(posedge i_ACLK) begin
        if (i_ARESET) r_rstate <= R_IDLE;
        else          r_rstate <= w_rnext;
    end

    // Read FSM next state and handshake outputs.
    always_comb begin
        w_rnext   = r_rstate;
        o_ARREADY = 1'b0;
        o_RVALID  = 1'b0;
        o_RLAST   = 1'b0;
        case (r_rstate)
            R_IDLE: begin
                o_ARREADY = 1'b1;
                if (i_ARVALID) w_rnext = R_DATA;
            end
            R_DATA: begin
                o_RVALID = 1'b1;
                o_RLAST  = w_rlast;
                if (i_RREADY && w_rlast) w_rnext = R_IDLE;
            end
            default: w_rnext = R_IDLE;
        endcase
    end

    // Read burst context and registered beat data, reloaded on AR and each R handshake.
    always_ff @(posedge i_ACLK) begin
        if (i_ARESET) begin
            r_arid    <= '0;
            r_araddr  <= '0;
            r_arlen   <= '0;
            r_arsize  <= '0;
            r_arburst <= '0;
            r_rbeat   <= '0;
            r_rdata   <= '0;
            r_rstrb   <= '0;
        end else if (w_rload) begin
            if (w_ridle) begin
                r_arid    <= i_ARID;
                r_arlen   <= i_ARLEN;
                r_arsize  <= i_ARSIZE;
                r_arburst <= i_ARBURST;
                r_rbeat   <= '0;
            end else begin
                r_rbeat <= r_rbeat + 8'd1;
            end
            r_araddr <= w_rsel_addr;
            r_rdata  <= w_rok ? r_mem[f_idx(w_rsel_addr)] : '0;
            r_rstrb  <= w_rok ? '1 : '0;
        end
    end
endmodule

// File: tb/tb_axi4_slave_mem.sv
// Self-checking bench for axi4_slave_mem: table of write/read-back bursts
// with a byte-accurate memory model, plus concurrency and reset sequences.
module tb_axi4_slave_mem;
    logic        clk = 1'b0;
    logic        i_ARESET;
    logic [5:0]  i_AWID, i_ARID;
    logic [31:0] i_AWADDR, i_ARADDR;
    logic [7:0]  i_AWLEN, i_ARLEN;
    logic [2:0]  i_AWSIZE, i_ARSIZE;
    logic [1:0]  i_AWBURST, i_ARBURST;
    logic        i_AWVALID, i_ARVALID;
    logic [63:0] i_WDATA;
    logic [7:0]  i_WSTRB;
    logic        i_WLAST, i_WVALID, i_BREADY, i_RREADY;
    logic        o_AWREADY, o_WREADY, o_BVALID, o_ARREADY;
    logic        o_RVALID, o_RLAST;
    logic [5:0]  o_BID, o_RID;
    logic [1:0]  o_BRESP;
    logic [63:0] o_RDATA;
    logic [7:0]  o_RSTRB;

    always #5 clk = ~clk;

    axi4_slave_mem dut (
        .i_ACLK(clk), .i_ARESET(i_ARESET),
        .i_AWID(i_AWID), .i_AWADDR(i_AWADDR), .i_AWLEN(i_AWLEN),
        .i_AWSIZE(i_AWSIZE), .i_AWBURST(i_AWBURST),
        .i_AWLOCK(2'b00), .i_AWCACHE(4'h0), .i_AWPROT(3'h0),
        .i_AWVALID(i_AWVALID), .o_AWREADY(o_AWREADY),
        .i_WDATA(i_WDATA), .i_WSTRB(i_WSTRB), .i_WLAST(i_WLAST),
        .i_WVALID(i_WVALID), .o_WREADY(o_WREADY),
        .o_BID(o_BID), .o_BRESP(o_BRESP), .o_BVALID(o_BVALID),
        .i_BREADY(i_BREADY),
        .i_ARID(i_ARID), .i_ARADDR(i_ARADDR), .i_ARLEN(i_ARLEN),
        .i_ARSIZE(i_ARSIZE), .i_ARBURST(i_ARBURST),
        .i_ARLOCK(2'b00), .i_ARCACHE(4'h0), .i_ARPROT(3'h0),
        .i_ARVALID(i_ARVALID), .o_ARREADY(o_ARREADY),
        .o_RID(o_RID), .o_RDATA(o_RDATA), .o_RSTRB(o_RSTRB),
        .o_RLAST(o_RLAST), .o_RVALID(o_RVALID), .i_RREADY(i_RREADY)
    );

    typedef struct {
        logic [5:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic [63:0] wd;
        logic [7:0]  strb;
        bit          nolast;
        bit          stall;
        logic [1:0]  bresp;
    } vec_t;

    typedef struct { logic [5:0] id; logic [1:0] resp; } bexp_t;
    typedef struct {
        logic [5:0]  id;
        logic [63:0] data;
        logic [7:0]  strb;
        logic        last;
    } rexp_t;

    bexp_t       bq[$];
    rexp_t       rq[$];
    logic [63:0] mdl [int];
    int          n_chk = 0;
    int          n_err = 0;
    vec_t        tbl[11];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        n_chk++;
        n_err++;
        $display("FAIL %s actual=timeout required=handshake", nm);
    endtask

    function automatic logic [31:0] beat_addr(input logic [31:0] a, input int i,
            input logic [2:0] size, input logic [7:0] len, input logic [1:0] burst);
        logic [31:0] inc, wsz, base;
        inc  = 32'd1 << ((size > 3'd3) ? 3'd3 : size);
        wsz  = inc * (32'(len) + 32'd1);
        base = a - (a % wsz);
        case (burst)
            2'b00:   return a;
            2'b10:   return base + ((a - base + 32'(i) * inc) % wsz);
            default: return a + 32'(i) * inc;
        endcase
    endfunction

    function automatic bit ok_addr(input logic [31:0] a, input logic [1:0] burst);
        return (a < 32'd8192) && (burst != 2'b11);
    endfunction

    task automatic b_collect();
        bexp_t e;
        bit    seen = 0;
        i_BREADY = 1'b1;
        for (int c = 0; c < 50 && !seen; c++) begin
            if (o_BVALID) begin
                seen = 1;
                e = bq.pop_front();
                chk("bid", 64'(o_BID), 64'(e.id));
                chk("bresp", 64'(o_BRESP), 64'(e.resp));
            end
            @(posedge clk); #1;
        end
        i_BREADY = 1'b0;
        if (!seen) timeout("b_wait");
        else chk("b_drop", 64'(o_BVALID), 64'd0);
    endtask

    task automatic wr_burst(input vec_t v);
        logic [31:0] a;
        logic [63:0] d, w;
        bit          rdy;
        int          c;
        bq.push_back('{v.id, v.bresp});
        for (int i = 0; i <= int'(v.len); i++) begin
            a = beat_addr(v.addr, i, v.size, v.len, v.burst);
            d = v.wd + 64'(i);
            if (ok_addr(a, v.burst)) begin
                w = mdl.exists(int'(a >> 3)) ? mdl[int'(a >> 3)] : 64'd0;
                for (int b = 0; b < 8; b++)
                    if (v.strb[b]) w[b*8 +: 8] = d[b*8 +: 8];
                mdl[int'(a >> 3)] = w;
            end
        end
        i_AWID = v.id; i_AWADDR = v.addr; i_AWLEN = v.len;
        i_AWSIZE = v.size; i_AWBURST = v.burst; i_AWVALID = 1'b1;
        c = 0;
        do begin
            rdy = o_AWREADY;
            @(posedge clk); #1;
            c++;
        end while (!rdy && c < 50);
        i_AWVALID = 1'b0;
        if (!rdy) timeout("aw_wait");
        for (int i = 0; i <= int'(v.len); i++) begin
            i_WDATA  = v.wd + 64'(i);
            i_WSTRB  = v.strb;
            i_WLAST  = !v.nolast && (i == int'(v.len));
            i_WVALID = 1'b1;
            c = 0;
            do begin
                rdy = o_WREADY;
                @(posedge clk); #1;
                c++;
            end while (!rdy && c < 50);
            if (!rdy) timeout("w_wait");
        end
        i_WVALID = 1'b0;
        i_WLAST  = 1'b0;
        b_collect();
    endtask

    task automatic ar_send(input logic [5:0] id, input logic [31:0] addr,
            input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
        logic [31:0] a;
        bit          rdy;
        int          c;
        for (int i = 0; i <= int'(len); i++) begin
            a = beat_addr(addr, i, size, len, burst);
            if (ok_addr(a, burst))
                rq.push_back('{id, mdl[int'(a >> 3)], 8'hFF, i == int'(len)});
            else
                rq.push_back('{id, 64'd0, 8'h00, i == int'(len)});
        end
        i_ARID = id; i_ARADDR = addr; i_ARLEN = len;
        i_ARSIZE = size; i_ARBURST = burst; i_ARVALID = 1'b1;
        c = 0;
        do begin
            rdy = o_ARREADY;
            @(posedge clk); #1;
            c++;
        end while (!rdy && c < 50);
        i_ARVALID = 1'b0;
        if (!rdy) timeout("ar_wait");
    endtask

    task automatic r_collect(input bit alt, input int nbeats);
        rexp_t e;
        bit    rr;
        int    got = 0;
        int    cyc = 0;
        while (got < nbeats && cyc < 200) begin
            rr = alt ? (cyc[0] == 1'b0) : 1'b1;
            i_RREADY = rr;
            if (o_RVALID) begin
                e = rq[0];
                if (rr) begin
                    void'(rq.pop_front());
                    got++;
                    chk("rid", 64'(o_RID), 64'(e.id));
                    chk("rdata", o_RDATA, e.data);
                    chk("rstrb", 64'(o_RSTRB), 64'(e.strb));
                    chk("rlast", 64'(o_RLAST), 64'(e.last));
                end else begin
                    chk("rdata_hold", o_RDATA, e.data);
                end
            end
            @(posedge clk); #1;
            cyc++;
        end
        i_RREADY = 1'b0;
        if (got < nbeats) timeout("r_wait");
    endtask

    initial begin
        vec_t vc;
        tbl[0]  = '{6'h2A, 32'h40,   8'd0, 3'd3, 2'b01, 64'h1122334455667788, 8'hFF, 0, 0, 2'b00};
        tbl[1]  = '{6'h05, 32'h100,  8'd3, 3'd3, 2'b01, 64'd1,                 8'hFF, 0, 1, 2'b00};
        tbl[2]  = '{6'h11, 32'h30,   8'd3, 3'd3, 2'b10, 64'hA0,                8'hFF, 0, 0, 2'b00};
        tbl[3]  = '{6'h3F, 32'h200,  8'd0, 3'd3, 2'b01, 64'hFFFFFFFFFFFFFFFF,  8'hFF, 0, 0, 2'b00};
        tbl[4]  = '{6'h3E, 32'h200,  8'd0, 3'd3, 2'b01, 64'd0,                 8'h0F, 0, 0, 2'b00};
        tbl[5]  = '{6'h01, 32'h0,    8'd0, 3'd3, 2'b01, 64'hDEADBEEFCAFEF00D,  8'hFF, 0, 0, 2'b00};
        tbl[6]  = '{6'h22, 32'h2000, 8'd0, 3'd3, 2'b01, 64'h5555AAAA5555AAAA,  8'hFF, 0, 0, 2'b10};
        tbl[7]  = '{6'h33, 32'h300,  8'd2, 3'd3, 2'b00, 64'h10,                8'hFF, 0, 1, 2'b00};
        tbl[8]  = '{6'h0C, 32'h308,  8'd0, 3'd3, 2'b11, 64'h77,                8'hFF, 0, 0, 2'b10};
        tbl[9]  = '{6'h14, 32'h500,  8'd1, 3'd7, 2'b01, 64'h9000,              8'hFF, 0, 0, 2'b00};
        tbl[10] = '{6'h09, 32'h600,  8'd1, 3'd3, 2'b01, 64'h6600,              8'hFF, 1, 0, 2'b10};

        i_ARESET = 1'b1;
        i_AWID = '0; i_AWADDR = '0; i_AWLEN = '0; i_AWSIZE = '0; i_AWBURST = '0;
        i_ARID = '0; i_ARADDR = '0; i_ARLEN = '0; i_ARSIZE = '0; i_ARBURST = '0;
        i_AWVALID = 0; i_ARVALID = 0; i_WDATA = '0; i_WSTRB = '0;
        i_WLAST = 0; i_WVALID = 0; i_BREADY = 0; i_RREADY = 0;
        repeat (3) @(posedge clk);
        #1;
        i_ARESET = 1'b0;

        chk("rst_awready", 64'(o_AWREADY), 64'd1);
        chk("rst_arready", 64'(o_ARREADY), 64'd1);
        chk("rst_wready", 64'(o_WREADY), 64'd0);
        chk("rst_bvalid", 64'(o_BVALID), 64'd0);
        chk("rst_rvalid", 64'(o_RVALID), 64'd0);
        chk("rst_rlast", 64'(o_RLAST), 64'd0);
        chk("rst_ids", 64'({o_BID, o_RID}), 64'd0);
        chk("rst_bresp", 64'(o_BRESP), 64'd0);
        chk("rst_rdata", o_RDATA, 64'd0);
        chk("rst_rstrb", 64'(o_RSTRB), 64'd0);

        for (int t = 0; t < 11; t++) begin
            wr_burst(tbl[t]);
            ar_send(tbl[t].id, tbl[t].addr, tbl[t].len, tbl[t].size, tbl[t].burst);
            r_collect(tbl[t].stall, int'(tbl[t].len) + 1);
        end

        ar_send(6'h02, 32'h0, 8'd0, 3'd3, 2'b01);
        r_collect(0, 1);

        vc = '{6'h18, 32'h700, 8'd1, 3'd3, 2'b01, 64'h7700, 8'hFF, 0, 0, 2'b00};
        fork
            wr_burst(vc);
            begin
                ar_send(6'h19, 32'h100, 8'd3, 3'd3, 2'b01);
                r_collect(0, 4);
            end
        join
        ar_send(6'h1A, 32'h700, 8'd1, 3'd3, 2'b01);
        r_collect(0, 2);

        ar_send(6'h07, 32'h100, 8'd3, 3'd3, 2'b01);
        r_collect(0, 2);
        i_ARESET = 1'b1;
        @(posedge clk); #1;
        i_ARESET = 1'b0;
        chk("mid_rst_rvalid", 64'(o_RVALID), 64'd0);
        chk("mid_rst_arready", 64'(o_ARREADY), 64'd1);
        rq.delete();
        ar_send(6'h08, 32'h108, 8'd0, 3'd3, 2'b01);
        r_collect(0, 1);

        chk("bq_empty", 64'(bq.size()), 64'd0);
        chk("rq_empty", 64'(rq.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
